// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared address map, chip FSM encoding and decode helper for the SRAM arbiter
package cpu_defs;

    localparam logic [31:0] BASE_BASE = 32'h8000_0000;
    localparam logic [31:0] EXT_BASE  = 32'h8040_0000;
    localparam int          RAM_AW    = 20;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_LOW   = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;

    localparam logic [1:0] MAP_NONE = 2'd0;
    localparam logic [1:0] MAP_BASE = 2'd1;
    localparam logic [1:0] MAP_EXT  = 2'd2;

    // Both windows are 4 MB, so only addr[31:22] selects the chip.
    function automatic logic [1:0] addr_map(input logic [31:0] a,
                                            input logic [31:0] base_win,
                                            input logic [31:0] ext_win);
        if (a[31:22] == base_win[31:22])
            return MAP_BASE;
        else if (a[31:22] == ext_win[31:22])
            return MAP_EXT;
        else
            return MAP_NONE;
    endfunction

endpackage

// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - one async SRAM chip: access FSM plus latched write pins
module sram_port_ctrl
    import cpu_defs::*;
#(
    parameter int AW    = 20,
    parameter int PULSE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [3:0]    cmd_be_n,
    input  logic [31:0]   cmd_wdata,
    output logic          ready,
    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_be_n,
    output logic          ram_ce_n,
    output logic          ram_oe_n,
    output logic          ram_we_n,
    output logic [31:0]   ram_wdata,
    output logic          ram_doe
);

    logic [2:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_busy;
    logic          rd_now;

    assign wr_busy = (state_q == ST_WR_SETUP) || (state_q == ST_WR_LOW) || (state_q == ST_WR_HOLD);
    // RD is a one-cycle bookkeeping state; the chip is free again, so reads can stream back-to-back.
    assign ready   = (state_q == ST_IDLE) || (state_q == ST_RD);
    assign rd_now  = go && !wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_RD: begin
                state_d = ST_IDLE;
                if (go) begin
                    state_d = wr ? ST_WR_SETUP : ST_RD;
                    if (wr) begin
                        addr_d  = cmd_addr;
                        be_d    = cmd_be_n;
                        wdata_d = cmd_wdata;
                    end
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_LOW;
                cnt_d   = 8'd0;
            end
            ST_WR_LOW: begin
                if (cnt_q == 8'(PULSE - 1))
                    state_d = ST_WR_HOLD;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            be_q    <= 4'hF;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Reads drive the pins in the grant cycle itself; writes replay the latched command.
    assign ram_ce_n  = !(wr_busy || rd_now);
    assign ram_oe_n  = !rd_now;
    assign ram_we_n  = (state_q != ST_WR_LOW);
    assign ram_doe   = wr_busy;
    assign ram_be_n  = wr_busy ? be_q : (rd_now ? 4'h0 : 4'hF);
    assign ram_addr  = rd_now ? cmd_addr : addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - decodes fetch/data requests onto base and ext SRAM, data side wins conflicts
module sram_arbiter #(
    parameter logic [31:0] BASE_BASE = cpu_defs::BASE_BASE,
    parameter logic [31:0] EXT_BASE  = cpu_defs::EXT_BASE,
    parameter int          RAM_AW    = cpu_defs::RAM_AW,
    parameter int          WR_PULSE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_en,
    input  logic [31:0]       inst_sram_addr,
    output logic [31:0]       inst_sram_rdata,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_we,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic              is_if_read,
    output logic              is_mem_read,
    output logic [RAM_AW-1:0] base_ram_addr,
    output logic [3:0]        base_ram_be_n,
    output logic              base_ram_ce_n,
    output logic              base_ram_oe_n,
    output logic              base_ram_we_n,
    output logic [31:0]       base_ram_wdata,
    output logic              base_ram_doe,
    input  logic [31:0]       base_ram_rdata,
    output logic [RAM_AW-1:0] ext_ram_addr,
    output logic [3:0]        ext_ram_be_n,
    output logic              ext_ram_ce_n,
    output logic              ext_ram_oe_n,
    output logic              ext_ram_we_n,
    output logic [31:0]       ext_ram_wdata,
    output logic              ext_ram_doe,
    input  logic [31:0]       ext_ram_rdata
);

    logic [1:0]  i_map, d_map;
    logic        i_base, i_ext, d_base, d_ext, d_wr;
    logic        base_rdy, ext_rdy, i_rdy, d_rdy, i_clash;
    logic        base_go, base_wr, ext_go, ext_wr, d_to_base, d_to_ext;
    logic [RAM_AW-1:0] base_cmd_addr, ext_cmd_addr;
    logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

    assign i_map  = cpu_defs::addr_map(inst_sram_addr, BASE_BASE, EXT_BASE);
    assign d_map  = cpu_defs::addr_map(data_sram_addr, BASE_BASE, EXT_BASE);
    assign i_base = (i_map == cpu_defs::MAP_BASE);
    assign i_ext  = (i_map == cpu_defs::MAP_EXT);
    assign d_base = (d_map == cpu_defs::MAP_BASE);
    assign d_ext  = (d_map == cpu_defs::MAP_EXT);
    assign d_wr   = |data_sram_we;

    // Unmapped accesses never touch a chip, so they are always grantable.
    assign i_rdy   = i_base ? base_rdy : (i_ext ? ext_rdy : 1'b1);
    assign d_rdy   = d_base ? base_rdy : (d_ext ? ext_rdy : 1'b1);
    assign i_clash = data_sram_en && (i_map == d_map) && (i_map != cpu_defs::MAP_NONE);

    assign is_mem_read = !reset && data_sram_en && d_rdy;
    assign is_if_read  = !reset && inst_sram_en && i_rdy && !i_clash;

    assign d_to_base     = is_mem_read && d_base;
    assign d_to_ext      = is_mem_read && d_ext;
    assign base_go       = d_to_base || (is_if_read && i_base);
    assign ext_go        = d_to_ext || (is_if_read && i_ext);
    assign base_wr       = d_to_base && d_wr;
    assign ext_wr        = d_to_ext && d_wr;
    assign base_cmd_addr = d_to_base ? data_sram_addr[RAM_AW+1:2] : inst_sram_addr[RAM_AW+1:2];
    assign ext_cmd_addr  = d_to_ext ? data_sram_addr[RAM_AW+1:2] : inst_sram_addr[RAM_AW+1:2];

    sram_port_ctrl #(.AW(RAM_AW), .PULSE(WR_PULSE)) u_base (
        .clk(clk), .rst(reset), .go(base_go), .wr(base_wr),
        .cmd_addr(base_cmd_addr), .cmd_be_n(~data_sram_we), .cmd_wdata(data_sram_wdata),
        .ready(base_rdy), .ram_addr(base_ram_addr), .ram_be_n(base_ram_be_n),
        .ram_ce_n(base_ram_ce_n), .ram_oe_n(base_ram_oe_n), .ram_we_n(base_ram_we_n),
        .ram_wdata(base_ram_wdata), .ram_doe(base_ram_doe)
    );

    sram_port_ctrl #(.AW(RAM_AW), .PULSE(WR_PULSE)) u_ext (
        .clk(clk), .rst(reset), .go(ext_go), .wr(ext_wr),
        .cmd_addr(ext_cmd_addr), .cmd_be_n(~data_sram_we), .cmd_wdata(data_sram_wdata),
        .ready(ext_rdy), .ram_addr(ext_ram_addr), .ram_be_n(ext_ram_be_n),
        .ram_ce_n(ext_ram_ce_n), .ram_oe_n(ext_ram_oe_n), .ram_we_n(ext_ram_we_n),
        .ram_wdata(ext_ram_wdata), .ram_doe(ext_ram_doe)
    );

    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (is_if_read)
            inst_rdata_d = i_base ? base_ram_rdata : (i_ext ? ext_ram_rdata : 32'h0);
        if (is_mem_read && !d_wr)
            data_rdata_d = d_base ? base_ram_rdata : (d_ext ? ext_ram_rdata : 32'h0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed checks of decode, arbitration, write sequencing and async reset
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        is_if_read, is_mem_read;
    logic [19:0] base_ram_addr, ext_ram_addr;
    logic [3:0]  base_ram_be_n, ext_ram_be_n;
    logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_doe;
    logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_doe;
    logic [31:0] base_ram_wdata, ext_ram_wdata, base_ram_rdata, ext_ram_rdata;

    logic [31:0] base_mem [0:255];
    logic [31:0] ext_mem  [0:255];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
        .is_if_read(is_if_read), .is_mem_read(is_mem_read),
        .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
        .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n), .base_ram_wdata(base_ram_wdata),
        .base_ram_doe(base_ram_doe), .base_ram_rdata(base_ram_rdata),
        .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
        .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n), .ext_ram_wdata(ext_ram_wdata),
        .ext_ram_doe(ext_ram_doe), .ext_ram_rdata(ext_ram_rdata)
    );

    // Async SRAM chip models: combinational read, byte-masked write while we_n is low.
    assign base_ram_rdata = base_mem[base_ram_addr[7:0]];
    assign ext_ram_rdata  = ext_mem[ext_ram_addr[7:0]];

    always @(posedge clk) begin
        if (!base_ram_we_n && !base_ram_ce_n)
            for (int b = 0; b < 4; b++)
                if (!base_ram_be_n[b]) base_mem[base_ram_addr[7:0]][8*b +: 8] <= base_ram_wdata[8*b +: 8];
        if (!ext_ram_we_n && !ext_ram_ce_n)
            for (int b = 0; b < 4; b++)
                if (!ext_ram_be_n[b]) ext_mem[ext_ram_addr[7:0]][8*b +: 8] <= ext_ram_wdata[8*b +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_sram_en    = 1'b0;
        inst_sram_addr  = 32'h0;
        data_sram_en    = 1'b0;
        data_sram_we    = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            base_mem[i] = 32'h0;
            ext_mem[i]  = 32'h0;
        end
        base_mem[4]    = 32'h1234_5678;
        base_mem[0]    = 32'hA0A0_0001;
        base_mem[8'h40] = 32'hB0B0_0002;
        ext_mem[2]     = 32'h1122_3344;

        reset = 1'b1;
        idle_inputs();
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'h8000_0010;
        step();
        step();
        #1;
        check("rst_base_ce_n", {31'd0, base_ram_ce_n}, 32'd1);
        check("rst_ext_ce_n", {31'd0, ext_ram_ce_n}, 32'd1);
        check("rst_oe_we", {28'd0, base_ram_oe_n, base_ram_we_n, ext_ram_oe_n, ext_ram_we_n}, 32'hF);
        check("rst_be_n", {24'd0, base_ram_be_n, ext_ram_be_n}, 32'hFF);
        check("rst_doe", {30'd0, base_ram_doe, ext_ram_doe}, 32'd0);
        check("rst_grants", {30'd0, is_if_read, is_mem_read}, 32'd0);
        check("rst_rdata", inst_sram_rdata | data_sram_rdata, 32'h0);
        idle_inputs();
        reset = 1'b0;

        // 1: single fetch from base
        step();
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'h8000_0010;
        #1;
        check("t1_if_grant", {31'd0, is_if_read}, 32'd1);
        check("t1_base_addr", {12'd0, base_ram_addr}, 32'd4);
        check("t1_ce_oe", {30'd0, base_ram_ce_n, base_ram_oe_n}, 32'd0);
        step();
        idle_inputs();
        #1;
        check("t1_inst_rdata", inst_sram_rdata, 32'h1234_5678);

        // 2: fetch and load collide on base, data wins
        step();
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'h8000_0000;
        data_sram_en = 1'b1;
        data_sram_addr = 32'h8000_0100;
        #1;
        check("t2_mem_grant", {31'd0, is_mem_read}, 32'd1);
        check("t2_if_withheld", {31'd0, is_if_read}, 32'd0);
        check("t2_base_addr", {12'd0, base_ram_addr}, 32'h40);
        step();
        data_sram_en = 1'b0;
        #1;
        check("t2_data_rdata", data_sram_rdata, 32'hB0B0_0002);
        check("t2_if_retry_grant", {31'd0, is_if_read}, 32'd1);
        step();
        idle_inputs();
        #1;
        check("t2_inst_rdata", inst_sram_rdata, 32'hA0A0_0001);

        // 3: fetch base + partial store ext in the same cycle
        step();
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'h8000_0010;
        data_sram_en = 1'b1;
        data_sram_we = 4'b0011;
        data_sram_addr = 32'h8040_0008;
        data_sram_wdata = 32'hAABB_CCDD;
        #1;
        check("t3_both_grant", {30'd0, is_if_read, is_mem_read}, 32'd3);
        step();
        idle_inputs();
        #1;
        check("t3_setup_be_n", {28'd0, ext_ram_be_n}, 32'b1100);
        check("t3_setup_pins", {28'd0, ext_ram_ce_n, ext_ram_we_n, ext_ram_doe, ext_ram_oe_n}, 32'b0111);
        check("t3_wdata", ext_ram_wdata, 32'hAABB_CCDD);
        check("t3_wr_addr", {12'd0, ext_ram_addr}, 32'd2);
        check("t3_inst_rdata", inst_sram_rdata, 32'h1234_5678);
        step();
        #1;
        check("t3_low_we_n", {31'd0, ext_ram_we_n}, 32'd0);
        step();
        #1;
        check("t3_hold_pins", {29'd0, ext_ram_ce_n, ext_ram_we_n, ext_ram_doe}, 32'b011);
        step();
        #1;
        check("t3_done_pins", {30'd0, ext_ram_ce_n, ext_ram_doe}, 32'b10);
        check("t3_mem_merge", ext_mem[2], 32'h1122_CCDD);

        // 4: store then load on ext, load held off until write finishes
        step();
        data_sram_en = 1'b1;
        data_sram_we = 4'hF;
        data_sram_addr = 32'h8040_000C;
        data_sram_wdata = 32'h5555_6666;
        #1;
        check("t4_store_grant", {31'd0, is_mem_read}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            data_sram_we = 4'h0;
            #1;
            check($sformatf("t4_load_wait%0d", c), {31'd0, is_mem_read}, 32'd0);
        end
        step();
        #1;
        check("t4_load_grant", {31'd0, is_mem_read}, 32'd1);
        step();
        idle_inputs();
        #1;
        check("t4_load_data", data_sram_rdata, 32'h5555_6666);

        // 5: unmapped load
        step();
        data_sram_en = 1'b1;
        data_sram_addr = 32'h9000_0000;
        #1;
        check("t5_grant", {31'd0, is_mem_read}, 32'd1);
        check("t5_no_ce", {30'd0, base_ram_ce_n, ext_ram_ce_n}, 32'd3);
        step();
        idle_inputs();
        #1;
        check("t5_rdata_zero", data_sram_rdata, 32'h0);

        // 6: reset lands in WR_LOW of a base store
        step();
        data_sram_en = 1'b1;
        data_sram_we = 4'hF;
        data_sram_addr = 32'h8000_0020;
        data_sram_wdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        step();
        #1;
        check("t6_in_low", {31'd0, base_ram_we_n}, 32'd0);
        reset = 1'b1;
        #1;
        check("t6_async_pins", {29'd0, base_ram_we_n, base_ram_ce_n, base_ram_doe}, 32'b110);
        check("t6_rdata_cleared", inst_sram_rdata, 32'h0);
        step();
        reset = 1'b0;
        step();
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'h8000_0010;
        #1;
        check("t6_fetch_after", {31'd0, is_if_read}, 32'd1);
        check("t6_write_lost", base_mem[8], 32'h0);
        step();
        idle_inputs();
        #1;
        check("t6_fetch_data", inst_sram_rdata, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
